clean_countdown_display: RTL
============================

// Module: clean_countdown_display
// PURPOSE
//  Downstream display stage of the range-hood self-clean controller. Consumes cleaning,
//  countdown (seconds, binary) and the done pulse from the self-clean FSM. Converts seconds
//  to M:SS sequentially (no dividers) and drives a 4-digit multiplexed 7-seg display.
//  Shows "End" blinking after completion, then blanks.
// PARAMETERS
//  SCAN_DIV    25_000      clk cycles per digit slot (100 MHz -> 1 kHz per digit)
//  BLINK_DIV   25_000_000  clk cycles per blink half-period in END mode
//  DONE_SHOWS  6           blink half-periods shown in END (on/off/on...) before blanking
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-high reset
//  cleaning   in   1  high while self-clean runs
//  countdown  in   8  remaining seconds, 0..255
//  done       in   1  one-cycle-or-longer completion pulse
//  seg        out  7  {g,f,e,d,c,b,a}, active-high
//  dp         out  1  decimal point of current digit, active-high (colon substitute)
//  an         out  4  one-hot digit enable, active-high; an[3] = leftmost digit
//  conv_busy  out  1  high while converter is mid-conversion
// BEHAVIOUR
//  Reset: all outputs 0, mode OFF, converter IDLE, digit regs 0, scan index 0, all counters 0.
//  Mode FSM (registered):
//   OFF   -> COUNT on cleaning=1; -> END on done=1 (done has priority).
//   COUNT -> END on done=1; -> OFF if cleaning=0 and done=0.
//   END   -> OFF after DONE_SHOWS blink half-periods. Ignores countdown and cleaning.
//           Re-entry needs done with mode != END.
//  Converter (sec_to_mmss), runs in COUNT only:
//   IDLE: if countdown != last_val or the cycle is COUNT entry -> capture into work reg,
//         set last_val, go DIV60.
//   DIV60: while work>=60: work-=60, min++ (1 step/cycle, max 4); else go DIV10.
//   DIV10: while work>=10: work-=10, tens++; else units=work, go COMMIT.
//   COMMIT: copy {min,tens,units} to display regs in one cycle (no torn digits), go IDLE.
//   Latency capture->display <= 11 cycles. conv_busy=1 in DIV60/DIV10/COMMIT.
//   countdown changes mid-conversion are ignored until IDLE, then re-captured.
//   Result is always the last stable value.
//  Display digits (left->right d3..d0):
//   COUNT: d3=0, d2=min (0..4), d1=tens (0..5), d0=units; dp=1 on d2 only.
//   END, blink-on half: d3='E', d2='n', d1='d', d0=blank, dp=0. Blink-off half: seg=0, an=0.
//   OFF: seg=0, dp=0, an=0.
//  Scan:
//   Divider counts 0..SCAN_DIV-1. On wrap, index = index+1 mod 4 (0->1->2->3->0).
//   an = 1<<index. seg/dp are registered and change in the same cycle as an.
//  Blink: counter counts only in END; cleared on END entry. First half-period is "on".
//  Reset mid-operation: immediate blank, all state to reset values. No partial digit commit.
// STRUCTURE
//  Package disp_pkg: mode encodings (OFF/COUNT/END), converter state encodings,
//   glyph constants GLYPH_0..9, GLYPH_E=7'b1111001, GLYPH_n=7'b1010100,
//   GLYPH_d=7'b1011110, GLYPH_BLANK=0.
//  Sub-module sec_to_mmss: converter FSM, ports clk,rst,start,val[7:0] ->
//   busy,valid,min[2:0],tens[2:0],units[3:0].
//  Top holds mode FSM, scan and blink counters, glyph mux.
// TESTING (SCAN_DIV=4, BLINK_DIV=8, DONE_SHOWS=4)
//  1 rst pulse mid-COUNT -> same cycle seg=0, an=0, dp=0, conv_busy=0.
//    Re-assert cleaning -> conversion restarts.
//  2 cleaning=1, countdown=180 -> within 11 clk digits 0,3,0,0.
//    Slot an=4'b0100: seg=7'b1001111, dp=1.
//  3 countdown 255 -> 0,4,1,5; 60 -> 0,1,0,0; 59 -> 0,0,5,9; 0 -> 0,0,0,0.
//    Check each after conv_busy falls.
//  4 countdown toggled 100/101 every 3 clk, then held 101 -> displayed digits never mixed.
//    Final digits 0,1,4,1.
//  5 done 1-cycle pulse during COUNT -> E,n,d shown for 8 clk, blank for 8 clk, repeat.
//    After 32 clk: OFF, an=0. countdown changes during END have no effect.
//  6 scan check in COUNT -> an sequence 0001,0010,0100,1000,0001, each held exactly 4 clk.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared encodings and glyph table for the self-clean countdown display.
// Latency: none (constants and a pure combinational lookup).
// Backpressure: not applicable.
package disp_pkg;

  // Display mode FSM encodings
  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_COUNT = 2'd1;
  localparam logic [1:0] MODE_END   = 2'd2;

  // Seconds-to-M:SS converter state encodings
  localparam logic [1:0] CONV_IDLE   = 2'd0;
  localparam logic [1:0] CONV_DIV60  = 2'd1;
  localparam logic [1:0] CONV_DIV10  = 2'd2;
  localparam logic [1:0] CONV_COMMIT = 2'd3;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] GLYPH_0     = 7'b0111111;
  localparam logic [6:0] GLYPH_1     = 7'b0000110;
  localparam logic [6:0] GLYPH_2     = 7'b1011011;
  localparam logic [6:0] GLYPH_3     = 7'b1001111;
  localparam logic [6:0] GLYPH_4     = 7'b1100110;
  localparam logic [6:0] GLYPH_5     = 7'b1101101;
  localparam logic [6:0] GLYPH_6     = 7'b1111101;
  localparam logic [6:0] GLYPH_7     = 7'b0000111;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1101111;
  localparam logic [6:0] GLYPH_E     = 7'b1111001;
  localparam logic [6:0] GLYPH_n     = 7'b1010100;
  localparam logic [6:0] GLYPH_d     = 7'b1011110;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  // Decimal digit to segment pattern; out-of-range digits show blank
  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sec_to_mmss.sv
// Sequential seconds (0..255) to minutes/tens/units converter using repeated subtraction.
// Latency: start accepted in IDLE; valid pulses in COMMIT at most 11 cycles later.
// Backpressure: start is ignored while busy; the caller re-requests once IDLE.
module sec_to_mmss
  import disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] val,
  output logic       busy,
  output logic       valid,
  output logic [2:0] min,
  output logic [2:0] tens,
  output logic [3:0] units
);

  logic [1:0] state_q, state_d;
  logic [7:0] work_q,  work_d;
  logic [2:0] min_q,   min_d;
  logic [2:0] tens_q,  tens_d;
  logic [3:0] units_q, units_d;

  // One subtraction per cycle: peel off minutes, then tens, then the remainder is units
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    min_d   = min_q;
    tens_d  = tens_q;
    units_d = units_q;
    case (state_q)
      CONV_IDLE: begin
        if (start) begin
          work_d  = val;
          min_d   = 3'd0;
          tens_d  = 3'd0;
          units_d = 4'd0;
          state_d = CONV_DIV60;
        end
      end
      CONV_DIV60: begin
        if (work_q >= 8'd60) begin
          work_d = work_q - 8'd60;
          min_d  = min_q + 3'd1;
        end else begin
          state_d = CONV_DIV10;
        end
      end
      CONV_DIV10: begin
        if (work_q >= 8'd10) begin
          work_d = work_q - 8'd10;
          tens_d = tens_q + 3'd1;
        end else begin
          units_d = work_q[3:0];
          state_d = CONV_COMMIT;
        end
      end
      default: begin
        state_d = CONV_IDLE;
      end
    endcase
  end

  // Converter state and working registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CONV_IDLE;
      work_q  <= 8'd0;
      min_q   <= 3'd0;
      tens_q  <= 3'd0;
      units_q <= 4'd0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      min_q   <= min_d;
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign busy  = (state_q != CONV_IDLE);
  assign valid = (state_q == CONV_COMMIT);
  assign min   = min_q;
  assign tens  = tens_q;
  assign units = units_q;

endmodule

// File: rtl/clean_countdown_display.sv
// Self-clean countdown display: M:SS during cleaning, blinking "End" after done, else blank.
// Latency: display outputs are registered (1 cycle after mode/scan state); digits update <= 11 cycles after a countdown change.
// Backpressure: none; countdown changes during a conversion are re-captured once the converter is idle.
module clean_countdown_display
  import disp_pkg::*;
#(
  parameter int SCAN_DIV   = 25_000,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int DONE_SHOWS = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cleaning,
  input  logic [7:0] countdown,
  input  logic       done,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       conv_busy
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SHOW_W  = $clog2(DONE_SHOWS + 1);

  logic [1:0]         mode_q, mode_d;
  logic               entry_pend_q, entry_pend_d;
  logic [7:0]         last_val_q, last_val_d;
  logic [2:0]         dig_min_q, dig_min_d;
  logic [2:0]         dig_tens_q, dig_tens_d;
  logic [3:0]         dig_units_q, dig_units_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [SHOW_W-1:0]  shows_q, shows_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [3:0]         an_q, an_d;

  logic       blink_wrap;
  logic       end_finished;
  logic       conv_start;
  logic       conv_capture;
  logic       conv_busy_w;
  logic       conv_valid;
  logic [2:0] conv_min;
  logic [2:0] conv_tens;
  logic [3:0] conv_units;

  assign blink_wrap   = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
  assign end_finished = blink_wrap && (shows_q == SHOW_W'(DONE_SHOWS - 1));

  // Mode FSM: done wins over cleaning; END runs its blink sequence to completion
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_OFF: begin
        if (done)          mode_d = MODE_END;
        else if (cleaning) mode_d = MODE_COUNT;
      end
      MODE_COUNT: begin
        if (done)          mode_d = MODE_END;
        else if (!cleaning) mode_d = MODE_OFF;
      end
      MODE_END: begin
        if (end_finished)  mode_d = MODE_OFF;
      end
      default: mode_d = MODE_OFF;
    endcase
  end

  // Request a conversion on COUNT entry or whenever countdown differs from the last captured value
  assign conv_start   = (mode_q == MODE_COUNT) && (entry_pend_q || (countdown != last_val_q));
  assign conv_capture = conv_start && !conv_busy_w;

  // Track the pending entry request and the last value handed to the converter
  always_comb begin
    entry_pend_d = entry_pend_q;
    last_val_d   = last_val_q;
    if (conv_capture) begin
      entry_pend_d = 1'b0;
      last_val_d   = countdown;
    end
    if ((mode_d == MODE_COUNT) && (mode_q != MODE_COUNT)) begin
      entry_pend_d = 1'b1;
    end
  end

  sec_to_mmss u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .val   (countdown),
    .busy  (conv_busy_w),
    .valid (conv_valid),
    .min   (conv_min),
    .tens  (conv_tens),
    .units (conv_units)
  );

  // Display digits move together on the converter's commit cycle so no torn value is shown
  always_comb begin
    dig_min_d   = dig_min_q;
    dig_tens_d  = dig_tens_q;
    dig_units_d = dig_units_q;
    if (conv_valid) begin
      dig_min_d   = conv_min;
      dig_tens_d  = conv_tens;
      dig_units_d = conv_units;
    end
  end

  // Free-running digit scan: advance the slot index each time the divider wraps
  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end
  end

  // Blink timing: cleared on END entry, counts half-periods only while in END
  always_comb begin
    blink_cnt_d = '0;
    shows_d     = '0;
    if ((mode_q == MODE_END) && (mode_d == MODE_END)) begin
      if (blink_wrap) begin
        blink_cnt_d = '0;
        shows_d     = shows_q + SHOW_W'(1);
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        shows_d     = shows_q;
      end
    end
  end

  // Glyph mux for the slot currently selected by the scan index
  always_comb begin
    seg_d = GLYPH_BLANK;
    dp_d  = 1'b0;
    an_d  = 4'b0000;
    case (mode_q)
      MODE_COUNT: begin
        an_d = 4'b0001 << idx_q;
        case (idx_q)
          2'd3: seg_d = GLYPH_0;
          2'd2: begin
            seg_d = digit_glyph({1'b0, dig_min_q});
            dp_d  = 1'b1;
          end
          2'd1: seg_d = digit_glyph({1'b0, dig_tens_q});
          default: seg_d = digit_glyph(dig_units_q);
        endcase
      end
      MODE_END: begin
        // Even half-periods are the visible ones, so the first one is "on"
        if (!shows_q[0]) begin
          an_d = 4'b0001 << idx_q;
          case (idx_q)
            2'd3:    seg_d = GLYPH_E;
            2'd2:    seg_d = GLYPH_n;
            2'd1:    seg_d = GLYPH_d;
            default: seg_d = GLYPH_BLANK;
          endcase
        end
      end
      default: begin
        seg_d = GLYPH_BLANK;
      end
    endcase
  end

  // All state registers; asynchronous reset blanks the display immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q       <= MODE_OFF;
      entry_pend_q <= 1'b0;
      last_val_q   <= 8'd0;
      dig_min_q    <= 3'd0;
      dig_tens_q   <= 3'd0;
      dig_units_q  <= 4'd0;
      scan_cnt_q   <= '0;
      idx_q        <= 2'd0;
      blink_cnt_q  <= '0;
      shows_q      <= '0;
      seg_q        <= 7'd0;
      dp_q         <= 1'b0;
      an_q         <= 4'd0;
    end else begin
      mode_q       <= mode_d;
      entry_pend_q <= entry_pend_d;
      last_val_q   <= last_val_d;
      dig_min_q    <= dig_min_d;
      dig_tens_q   <= dig_tens_d;
      dig_units_q  <= dig_units_d;
      scan_cnt_q   <= scan_cnt_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      shows_q      <= shows_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign an        = an_q;
  assign conv_busy = conv_busy_w;

endmodule
